// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory line port between the icache and dcache.
// One transaction in flight; request latched at arbitration, responses steered to the owner only.
module mem_arbiter #(
    parameter int PADDR_WIDTH    = 20,
    parameter int LINE_BYTES     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      i_req_i,
    input  logic [PADDR_WIDTH-1:0]    i_addr_i,
    output logic                      i_gnt_o,
    output logic                      i_rvalid_o,
    output logic [LINE_BYTES*8-1:0]   i_rdata_o,
    input  logic                      d_req_i,
    input  logic                      d_we_i,
    input  logic [PADDR_WIDTH-1:0]    d_addr_i,
    input  logic [LINE_BYTES*8-1:0]   d_wdata_i,
    output logic                      d_gnt_o,
    output logic                      d_rvalid_o,
    output logic [LINE_BYTES*8-1:0]   d_rdata_o,
    output logic                      d_write_done_o,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [PADDR_WIDTH-1:0]    mem_addr_o,
    output logic [LINE_BYTES*8-1:0]   mem_wdata_o,
    input  logic                      mem_gnt_i,
    input  logic                      mem_rvalid_i,
    input  logic [LINE_BYTES*8-1:0]   mem_rdata_i,
    input  logic                      mem_write_done_i,
    output logic                      busy_o,
    output logic                      err_timeout_o
);
    localparam int DW = LINE_BYTES * 8;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    r_owner_d;
    logic                    r_last_d;
    logic                    r_we;
    logic [PADDR_WIDTH-1:0]  r_addr;
    logic [DW-1:0]           r_wdata;
    logic [CW-1:0]           r_cnt;
    logic                    r_mem_req;
    logic                    r_busy;
    logic                    r_err;

    logic                    w_any_req;
    logic                    w_pick_d;
    logic                    w_issue_gnt;
    logic                    w_resp_window;
    logic                    w_rd_done;
    logic                    w_wr_done;
    logic                    w_done;
    logic                    w_timeout;

    // On a tie the requester that did not win last time goes first.
    assign w_any_req     = i_req_i | d_req_i;
    assign w_pick_d      = d_req_i & (~i_req_i | ~r_last_d);
    assign w_issue_gnt   = (r_state == ST_ISSUE) & mem_gnt_i;
    assign w_resp_window = (r_state == ST_WAIT) | w_issue_gnt;
    assign w_rd_done     = w_resp_window & ~r_we & mem_rvalid_i;
    assign w_wr_done     = w_resp_window & r_we & mem_write_done_i;
    assign w_done        = w_rd_done | w_wr_done;
    assign w_timeout     = (r_state == ST_WAIT) & ~w_done & (r_cnt == TO_LAST);

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) w_next_state = ST_ISSUE;
                else           w_next_state = ST_IDLE;
            end
            ST_ISSUE: begin
                if (w_issue_gnt && w_done) w_next_state = ST_IDLE;
                else if (w_issue_gnt)      w_next_state = ST_WAIT;
                else                       w_next_state = ST_ISSUE;
            end
            ST_WAIT: begin
                if (w_done || w_timeout) w_next_state = ST_IDLE;
                else                     w_next_state = ST_WAIT;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Latched request, ownership, watchdog and registered memory-side outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_owner_d <= 1'b0;
            r_last_d  <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= {PADDR_WIDTH{1'b0}};
            r_wdata   <= {DW{1'b0}};
            r_cnt     <= {CW{1'b0}};
            r_mem_req <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && w_any_req) begin
                r_owner_d <= w_pick_d;
                r_last_d  <= w_pick_d;
                r_we      <= w_pick_d & d_we_i;
                r_addr    <= w_pick_d ? d_addr_i : i_addr_i;
                r_wdata   <= w_pick_d ? d_wdata_i : {DW{1'b0}};
            end
            if (w_issue_gnt) begin
                r_cnt <= {CW{1'b0}};
            end else if ((r_state == ST_WAIT) && !w_done) begin
                r_cnt <= r_cnt + CW'(1);
            end
            r_mem_req <= (w_next_state == ST_ISSUE);
            r_busy    <= (w_next_state != ST_IDLE);
            r_err     <= r_err | w_timeout;
        end
    end

    // Grant and response steering; rdata is zero unless its rvalid is forwarded.
    always_comb begin
        i_gnt_o        = w_issue_gnt & ~r_owner_d;
        d_gnt_o        = w_issue_gnt & r_owner_d;
        i_rvalid_o     = w_rd_done & ~r_owner_d;
        d_rvalid_o     = w_rd_done & r_owner_d;
        d_write_done_o = w_wr_done & r_owner_d;
        if (w_rd_done && !r_owner_d) i_rdata_o = mem_rdata_i;
        else                         i_rdata_o = {DW{1'b0}};
        if (w_rd_done && r_owner_d)  d_rdata_o = mem_rdata_i;
        else                         d_rdata_o = {DW{1'b0}};
    end

    assign mem_req_o     = r_mem_req;
    assign mem_we_o      = r_we;
    assign mem_addr_o    = r_addr;
    assign mem_wdata_o   = r_wdata;
    assign busy_o        = r_busy;
    assign err_timeout_o = r_err;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: requester agents, a memory responder and a
// transaction-level reference of round-robin ownership, timeout and reset behaviour.
module tb_mem_arbiter;
    localparam int AW = 20;
    localparam int DW = 128;
    localparam int TO = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          i_req_i, d_req_i, d_we_i;
    logic [AW-1:0] i_addr_i, d_addr_i;
    logic [DW-1:0] d_wdata_i;
    logic          i_gnt_o, i_rvalid_o, d_gnt_o, d_rvalid_o, d_write_done_o;
    logic [DW-1:0] i_rdata_o, d_rdata_o;
    logic          mem_req_o, mem_we_o, busy_o, err_timeout_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_gnt_i, mem_rvalid_i, mem_write_done_i;
    logic [DW-1:0] mem_rdata_i;

    mem_arbiter #(.PADDR_WIDTH(AW), .LINE_BYTES(16), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_gnt_o(i_gnt_o),
        .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
        .d_write_done_o(d_write_done_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .mem_write_done_i(mem_write_done_i),
        .busy_o(busy_o), .err_timeout_o(err_timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: which agents hold a request, who won last, sticky error.
    bit            ip, dp, last_d, err_exp, owner_d, exp_we, tie_next;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata, line;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic next_cyc();
        @(negedge clk_i);
        #1;
    endtask

    function automatic logic [DW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_no_fwd(input string tag);
        check_eq(tag, {i_rvalid_o, d_rvalid_o, d_write_done_o, i_rdata_o | d_rdata_o}, '0);
    endtask

    task automatic drive_resp(input bit we, input logic [DW-1:0] l);
        if (we) begin
            mem_write_done_i = 1'b1;
            mem_rvalid_i     = 1'b1;
            mem_rdata_i      = rand_line();
        end else begin
            mem_rvalid_i     = 1'b1;
            mem_rdata_i      = l;
            mem_write_done_i = 1'($urandom % 2);
        end
    endtask

    task automatic clear_resp();
        mem_rvalid_i     = 1'b0;
        mem_write_done_i = 1'b0;
        mem_rdata_i      = '0;
    endtask

    task automatic check_resp(input string tag, input bit od, input bit we, input logic [DW-1:0] l);
        logic [2:0] exp_flags;
        if (we)      exp_flags = 3'b001;
        else if (od) exp_flags = 3'b010;
        else         exp_flags = 3'b100;
        check_eq({tag, "_flags"}, {i_rvalid_o, d_rvalid_o, d_write_done_o}, exp_flags);
        check_eq({tag, "_i_rdata"}, i_rdata_o, (!we && !od) ? l : '0);
        check_eq({tag, "_d_rdata"}, d_rdata_o, (!we && od) ? l : '0);
    endtask

    task automatic raise_i(input logic [AW-1:0] a);
        ip = 1'b1; i_req_i = 1'b1; i_addr_i = a;
    endtask

    task automatic raise_d(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        dp = 1'b1; d_req_i = 1'b1; d_we_i = we; d_addr_i = a; d_wdata_i = wd;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ctl"}, {busy_o, mem_req_o, mem_we_o, err_timeout_o, i_gnt_o, d_gnt_o,
                                 i_rvalid_o, d_rvalid_o, d_write_done_o}, '0);
        check_eq({tag, "_addr"}, mem_addr_o, '0);
        check_eq({tag, "_data"}, mem_wdata_o | i_rdata_o | d_rdata_o, '0);
    endtask

    initial begin
        int g, lat;
        bit timeout, do_rst, drop;
        rst_i = 1'b0;
        i_req_i = 1'b0; d_req_i = 1'b0; d_we_i = 1'b0;
        i_addr_i = '0; d_addr_i = '0; d_wdata_i = '0;
        mem_gnt_i = 1'b0;
        clear_resp();
        ip = 1'b0; dp = 1'b0; last_d = 1'b0; err_exp = 1'b0; tie_next = 1'b0;
        next_cyc();
        check_all_zero("reset");
        rst_i = 1'b1;
        next_cyc();

        for (int r = 0; r < 48; r++) begin
            // IDLE cycle: a stray response must not be forwarded.
            mem_rvalid_i = 1'($urandom % 2);
            mem_write_done_i = 1'($urandom % 2);
            mem_rdata_i = rand_line();
            g = $urandom % 3; lat = $urandom % 4;
            timeout = ($urandom % 8) == 0; do_rst = 1'b0; drop = ($urandom % 4) == 0;
            line = rand_line();
            if (r == 0) begin
                raise_i(20'h01230); line = {16{8'hA5}}; g = 2; lat = 3; timeout = 1'b0;
            end else if (r == 1) begin
                raise_d(1'b1, 20'h00FF0, 128'h0123456789ABCDEF_FEDCBA9876543210); timeout = 1'b0;
            end else if (tie_next || (r >= 2 && r <= 5)) begin
                if (!ip) raise_i(20'($urandom));
                if (!dp) raise_d(1'($urandom % 2), 20'($urandom), rand_line());
                tie_next = 1'b0;
            end else begin
                if (!ip && ($urandom % 2) == 1) raise_i(20'($urandom));
                if (!dp && ($urandom % 2) == 1) raise_d(1'($urandom % 2), 20'($urandom), rand_line());
                if (!ip && !dp) raise_i(20'($urandom));
            end
            if (r == 8)  begin timeout = 1'b1; lat = 1; end
            if (r == 20) begin do_rst = 1'b1; timeout = 1'b0; lat = 2; end
            #1;
            check_eq("idle_stray_ignored", {i_gnt_o, d_gnt_o, i_rvalid_o, d_rvalid_o, d_write_done_o}, '0);

            owner_d   = dp && (!ip || !last_d);
            last_d    = owner_d;
            exp_we    = owner_d ? d_we_i : 1'b0;
            exp_addr  = owner_d ? d_addr_i : i_addr_i;
            exp_wdata = d_wdata_i;

            next_cyc();
            clear_resp();
            #1;
            check_eq("issue_req", {mem_req_o, busy_o, mem_we_o}, {1'b1, 1'b1, exp_we});
            check_eq("issue_addr", mem_addr_o, exp_addr);
            if (exp_we) check_eq("issue_wdata", mem_wdata_o, exp_wdata);

            for (int k = 0; k < g; k++) begin
                check_eq("gnt_early", {i_gnt_o, d_gnt_o, mem_req_o}, 3'b001);
                next_cyc();
                #1;
            end
            mem_gnt_i = 1'b1;
            if (lat == 0) drive_resp(exp_we, line);
            #1;
            check_eq("gnt_owner", {i_gnt_o, d_gnt_o}, owner_d ? 2'b01 : 2'b10);
            if (lat == 0) check_resp("resp_in_issue", owner_d, exp_we, line);
            next_cyc();
            mem_gnt_i = 1'b0;
            clear_resp();
            if (drop) begin
                if (owner_d) d_req_i = 1'b0; else i_req_i = 1'b0;
            end

            if (do_rst) begin
                rst_i = 1'b0;
                #1;
                check_all_zero("async_reset");
                next_cyc();
                rst_i = 1'b1;
                i_req_i = 1'b0; d_req_i = 1'b0;
                ip = 1'b0; dp = 1'b0; last_d = 1'b0; err_exp = 1'b0; tie_next = 1'b1;
                next_cyc();
                continue;
            end

            if (lat != 0 && timeout) begin
                for (int c = 0; c < TO; c++) begin
                    #1;
                    check_eq("wd_wait", {err_timeout_o, busy_o}, {err_exp, 1'b1});
                    check_no_fwd("wd_no_resp");
                    next_cyc();
                end
                err_exp = 1'b1;
            end else if (lat != 0) begin
                for (int c = 0; c < lat - 1; c++) begin
                    #1;
                    check_no_fwd("wait_no_resp");
                    next_cyc();
                end
                drive_resp(exp_we, line);
                #1;
                check_resp("resp_in_wait", owner_d, exp_we, line);
                next_cyc();
                clear_resp();
            end
            #1;
            check_eq("back_idle", {busy_o, mem_req_o, err_timeout_o}, {1'b0, 1'b0, err_exp});
            if (owner_d) begin d_req_i = 1'b0; dp = 1'b0; end
            else         begin i_req_i = 1'b0; ip = 1'b0; end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
